mem_bank_scheduler: RTL

//  Per-memory-module access scheduler. One instance sits in front of each shared memory bank.

---
 rtl/mem_bank_scheduler_pkg.sv | 21 ++
 rtl/mem_bank_scheduler_if.sv | 36 +++
 rtl/mem_bank_scheduler_rr_prio_picker.sv | 70 +++++++
 rtl/mem_bank_scheduler.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bank_scheduler_pkg.sv
// Shared defaults, FSM encoding and small helpers for the bank scheduler slice.
package mem_bank_scheduler_pkg;

  localparam int N_CORES         = 4;
  localparam int PRI_BITS        = 2;
  localparam int LOCAL_ADDR_BITS = 8;
  localparam int ACC_LAT_DEF     = 2;
  localparam int AGE_MAX_DEF     = 7;

  typedef enum logic [1:0] {
    SCHED_IDLE = 2'd0,
    SCHED_CMD  = 2'd1,
    SCHED_BUSY = 2'd2
  } sched_state_e;

  // Index width that never collapses to zero bits.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bank_scheduler_if.sv
// Request/grant and bank command bundle between the cores and one bank scheduler.
interface mem_bank_scheduler_if
  import mem_bank_scheduler_pkg::*;
#(
  parameter int N_REQ  = N_CORES,
  parameter int PRI_W  = PRI_BITS,
  parameter int ADDR_W = LOCAL_ADDR_BITS
);
  localparam int SRC_W = idx_w(N_REQ);

  logic [N_REQ-1:0]        req_vld;
  logic [N_REQ-1:0]        req_rw;
  logic [N_REQ*PRI_W-1:0]  req_pri;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_gnt;
  logic [N_REQ-1:0]        req_retry;
  logic                    bank_cmd_vld;
  logic                    bank_cmd_rdy;
  logic                    bank_cmd_rw;
  logic [ADDR_W-1:0]       bank_cmd_addr;
  logic [SRC_W-1:0]        bank_cmd_src;
  logic                    sched_busy;

  modport slave (
    input  req_vld, req_rw, req_pri, req_addr, bank_cmd_rdy,
    output req_gnt, req_retry, bank_cmd_vld, bank_cmd_rw, bank_cmd_addr,
           bank_cmd_src, sched_busy
  );

  modport master (
    output req_vld, req_rw, req_pri, req_addr, bank_cmd_rdy,
    input  req_gnt, req_retry, bank_cmd_vld, bank_cmd_rw, bank_cmd_addr,
           bank_cmd_src, sched_busy
  );

endinterface

// File: rtl/mem_bank_scheduler_rr_prio_picker.sv
// Combinational picker: saturated-age class first, else highest priority,
// ties broken by the first candidate at or after the round-robin pointer.
module rr_prio_picker
  import mem_bank_scheduler_pkg::*;
#(
  parameter int N_REQ = N_CORES,
  parameter int PRI_W = PRI_BITS,
  parameter int IDX_W = idx_w(N_CORES)
) (
  input  logic [N_REQ-1:0]       i_vld,
  input  logic [N_REQ*PRI_W-1:0] i_pri,
  input  logic [N_REQ-1:0]       i_age_sat,
  input  logic [IDX_W-1:0]       i_rr_ptr,
  output logic                   o_any,
  output logic [IDX_W-1:0]       o_winner
);

  logic [PRI_W-1:0] w_max_pri;
  logic [N_REQ-1:0] w_sat_vld;
  logic [N_REQ-1:0] w_cand;
  logic             w_found;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_win;

  assign w_sat_vld = i_vld & i_age_sat;
  assign o_any     = |i_vld;
  assign o_winner  = w_win;

  // Highest priority among valid requesters.
  always_comb begin
    w_max_pri = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_vld[i] && (i_pri[i*PRI_W +: PRI_W] > w_max_pri)) begin
        w_max_pri = i_pri[i*PRI_W +: PRI_W];
      end else begin
        w_max_pri = w_max_pri;
      end
    end
  end

  // Candidate class: starving requesters override priority entirely.
  always_comb begin
    w_cand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (|w_sat_vld) begin
        w_cand[i] = w_sat_vld[i];
      end else begin
        w_cand[i] = i_vld[i] && (i_pri[i*PRI_W +: PRI_W] == w_max_pri);
      end
    end
  end

  // Circular scan starting at the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = i_rr_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && w_cand[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end else begin
        w_found = w_found;
        w_win   = w_win;
      end
      w_idx = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/mem_bank_scheduler.sv
// Per-bank access scheduler: grants one core per bank access, retries the rest,
// and walks the bank through its command and busy phases.
module mem_bank_scheduler
  import mem_bank_scheduler_pkg::*;
#(
  parameter int N_REQ   = N_CORES,
  parameter int PRI_W   = PRI_BITS,
  parameter int ADDR_W  = LOCAL_ADDR_BITS,
  parameter int ACC_LAT = ACC_LAT_DEF,
  parameter int AGE_MAX = AGE_MAX_DEF
) (
  input logic                 clk,
  input logic                 rst,
  mem_bank_scheduler_if.slave bus
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam int AGE_W = idx_w(AGE_MAX + 1);
  localparam int CNT_W = idx_w(ACC_LAT + 1);
  localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(AGE_MAX);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_LAT);

  sched_state_e      r_state;
  sched_state_e      w_state_nxt;
  logic [CNT_W-1:0]  r_busy_cnt;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [AGE_W-1:0]  r_age [N_REQ];
  logic [N_REQ-1:0]  r_gnt;
  logic [N_REQ-1:0]  r_retry;
  logic              r_cmd_vld;
  logic              r_cmd_rw;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic [IDX_W-1:0]  r_cmd_src;
  logic              r_busy;

  logic              w_any;
  logic [IDX_W-1:0]  w_winner;
  logic [N_REQ-1:0]  w_win_oh;
  logic [N_REQ-1:0]  w_age_sat;
  logic              w_fire;
  logic              w_hs;
  logic [N_REQ-1:0]  w_gnt_nxt;
  logic [N_REQ-1:0]  w_retry_nxt;
  logic              w_rw_sel;
  logic [ADDR_W-1:0] w_addr_sel;
  logic [IDX_W-1:0]  w_rr_nxt;

  rr_prio_picker #(
    .N_REQ (N_REQ),
    .PRI_W (PRI_W),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_vld     (bus.req_vld),
    .i_pri     (bus.req_pri),
    .i_age_sat (w_age_sat),
    .i_rr_ptr  (r_rr_ptr),
    .o_any     (w_any),
    .o_winner  (w_winner)
  );

  assign w_win_oh = N_REQ'(1'b1) << w_winner;
  assign w_rr_nxt = (w_winner == IDX_W'(N_REQ - 1)) ? '0 : w_winner + IDX_W'(1);

  // Per-core starvation flags.
  always_comb begin
    w_age_sat = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_age_sat[i] = (r_age[i] == AGE_SAT);
    end
  end

  // Winner's rw/address mux; other cores' fields are never stored.
  always_comb begin
    w_rw_sel   = 1'b0;
    w_addr_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_winner == IDX_W'(i)) begin
        w_rw_sel   = bus.req_rw[i];
        w_addr_sel = bus.req_addr[i*ADDR_W +: ADDR_W];
      end else begin
        w_rw_sel   = w_rw_sel;
        w_addr_sel = w_addr_sel;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SCHED_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state plus next grant/retry vectors.
  always_comb begin
    w_state_nxt = r_state;
    w_fire      = 1'b0;
    w_hs        = 1'b0;
    w_gnt_nxt   = '0;
    w_retry_nxt = '0;
    case (r_state)
      SCHED_IDLE: begin
        w_fire = w_any;
        if (w_any) begin
          w_state_nxt = SCHED_CMD;
          w_gnt_nxt   = w_win_oh;
          w_retry_nxt = bus.req_vld & ~w_win_oh;
        end else begin
          w_state_nxt = SCHED_IDLE;
        end
      end
      SCHED_CMD: begin
        w_hs        = r_cmd_vld & bus.bank_cmd_rdy;
        w_retry_nxt = bus.req_vld;
        if (w_hs) begin
          w_state_nxt = SCHED_BUSY;
        end else begin
          w_state_nxt = SCHED_CMD;
        end
      end
      SCHED_BUSY: begin
        w_retry_nxt = bus.req_vld;
        if (r_busy_cnt <= CNT_W'(1)) begin
          w_state_nxt = SCHED_IDLE;
        end else begin
          w_state_nxt = SCHED_BUSY;
        end
      end
      default: begin
        w_state_nxt = SCHED_IDLE;
      end
    endcase
  end

  // Registered outputs, latched command, busy counter and rr pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt      <= '0;
      r_retry    <= '0;
      r_busy     <= 1'b0;
      r_cmd_vld  <= 1'b0;
      r_cmd_rw   <= 1'b0;
      r_cmd_addr <= '0;
      r_cmd_src  <= '0;
      r_rr_ptr   <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_gnt   <= w_gnt_nxt;
      r_retry <= w_retry_nxt;
      r_busy  <= (w_state_nxt != SCHED_IDLE);
      if (w_fire) begin
        r_cmd_vld  <= 1'b1;
        r_cmd_rw   <= w_rw_sel;
        r_cmd_addr <= w_addr_sel;
        r_cmd_src  <= w_winner;
        r_rr_ptr   <= w_rr_nxt;
      end else if (w_hs) begin
        r_cmd_vld <= 1'b0;
      end
      if (w_hs) begin
        r_busy_cnt <= CNT_LOAD;
      end else if ((r_state == SCHED_BUSY) && (r_busy_cnt != '0)) begin
        r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      end
    end
  end

  // Ages grow while a core keeps being retried; a grant or dropped valid clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (bus.req_vld[i] && !w_gnt_nxt[i]) begin
          r_age[i] <= (r_age[i] == AGE_SAT) ? r_age[i] : r_age[i] + AGE_W'(1);
        end else begin
          r_age[i] <= '0;
        end
      end
    end
  end

  assign bus.req_gnt       = r_gnt;
  assign bus.req_retry     = r_retry;
  assign bus.bank_cmd_vld  = r_cmd_vld;
  assign bus.bank_cmd_rw   = r_cmd_rw;
  assign bus.bank_cmd_addr = r_cmd_addr;
  assign bus.bank_cmd_src  = r_cmd_src;
  assign bus.sched_busy    = r_busy;

endmodule
